// File: rtl/seq_magnitude_comparator_if.sv
// Request/result bundle for the sequential magnitude comparator.
// The master drives the operands, mode and cascade inputs; the slave returns the handshake and the L/E/G result.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             l;
  logic             e;
  logic             g;
  logic             busy;
  logic             done;
  logic             L;
  logic             E;
  logic             G;

  modport master (
    output start, sgn, a, b, l, e, g,
    input  busy, done, L, E, G
  );

  modport slave (
    input  start, sgn, a, b, l, e, g,
    output busy, done, L, E, G
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude compare, one DIGIT-bit digit per cycle from the MSB, exiting at the first difference.
// Latency 1..N cycles after the start edge; start is ignored while busy, and accepted again in the done cycle.
module seq_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic                  clk,
  input logic                  rst,
  seq_magnitude_comparator_if.slave bus
);
  localparam int N    = WIDTH / DIGIT;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

  typedef enum logic {S_IDLE, S_COMPARE} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_sgn;
  logic              r_l;
  logic              r_e;
  logic              r_g;
  logic [IDXW-1:0]   r_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_L;
  logic              r_E;
  logic              r_G;

  logic [DIGIT-1:0]  w_da;
  logic [DIGIT-1:0]  w_db;
  logic [DIGIT-1:0]  w_da_c;
  logic [DIGIT-1:0]  w_db_c;
  logic              w_flip;
  logic              w_gt;
  logic              w_lt;

  always_comb begin
    w_da = '0;
    w_db = '0;
    for (int i = 0; i < N; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_da = r_a[i*DIGIT +: DIGIT];
        w_db = r_b[i*DIGIT +: DIGIT];
      end
    end
    // Inverting the sign bit maps two's-complement order onto unsigned order.
    w_flip = r_sgn && (r_idx == IDXW'(N - 1));
    w_da_c = w_flip ? (w_da ^ MSB_MASK) : w_da;
    w_db_c = w_flip ? (w_db ^ MSB_MASK) : w_db;
  end

  assign w_gt = (w_da_c > w_db_c);
  assign w_lt = (w_da_c < w_db_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_l     <= 1'b0;
      r_e     <= 1'b0;
      r_g     <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_L     <= 1'b0;
      r_E     <= 1'b0;
      r_G     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sgn   <= bus.sgn;
            r_l     <= bus.l;
            r_e     <= bus.e;
            r_g     <= bus.g;
            r_idx   <= IDXW'(N - 1);
            r_busy  <= 1'b1;
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (w_gt || w_lt) begin
            r_L     <= w_lt;
            r_E     <= 1'b0;
            r_G     <= w_gt;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_idx == '0) begin
            // All digits equal: the lower-order stage decides, passed through as-is.
            r_L     <= r_l;
            r_E     <= r_e;
            r_G     <= r_g;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx - IDXW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.L    = r_L;
  assign bus.E    = r_E;
  assign bus.G    = r_G;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=16, DIGIT=4) with a per-cycle reference model
// and literal expectations for latency and result of each directed operation.
module tb_seq_magnitude_comparator;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  seq_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

  seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: result from plain signed/unsigned arithmetic, latency from the count of leading equal digits.
  function automatic logic [2:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic sgn, input logic [2:0] leg);
    if (sgn) begin
      if ($signed(a) < $signed(b)) return 3'b100;
      if ($signed(a) > $signed(b)) return 3'b001;
    end else begin
      if (a < b) return 3'b100;
      if (a > b) return 3'b001;
    end
    return leg;
  endfunction

  function automatic int digits_examined(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int i = N - 1; i >= 0; i--) begin
      if (((a >> (DIGIT * i)) & 16'hF) != ((b >> (DIGIT * i)) & 16'hF)) return N - i;
    end
    return N;
  endfunction

  logic       m_busy;
  logic       m_done;
  logic [2:0] m_leg;
  logic [2:0] m_pend;
  int         m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_leg  <= 3'b000;
      m_pend <= 3'b000;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_leg  <= m_pend;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (bus.start) begin
        m_busy <= 1'b1;
        m_cnt  <= digits_examined(bus.a, bus.b);
        m_pend <= ref_result(bus.a, bus.b, bus.sgn, {bus.l, bus.e, bus.g});
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_busy", int'(bus.busy), int'(m_busy));
      chk("mon_done", int'(bus.done), int'(m_done));
      chk("mon_leg", int'({bus.L, bus.E, bus.G}), int'(m_leg));
    end
  end

  // Called at a falling edge; leaves start low one cycle later, when the DUT is busy.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sgn, input logic [2:0] leg);
    bus.a     = a;
    bus.b     = b;
    bus.sgn   = sgn;
    {bus.l, bus.e, bus.g} = leg;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic [2:0] exp_leg);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1'b1;
    end
    chk({name, "_lat"}, cyc, exp_lat);
    chk({name, "_leg"}, int'({bus.L, bus.E, bus.G}), int'(exp_leg));
  endtask

  initial begin
    int nd;
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    {bus.l, bus.e, bus.g} = 3'b010;

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_leg", int'({bus.L, bus.E, bus.G}), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    issue(16'h1234, 16'h1235, 1'b0, 3'b010);
    wait_done("lsb_diff", 4, 3'b100);

    issue(16'h9000, 16'h1000, 1'b0, 3'b010);
    wait_done("msb_uns", 1, 3'b001);
    issue(16'h9000, 16'h1000, 1'b1, 3'b010);
    wait_done("msb_sgn", 1, 3'b100);

    issue(16'hBEEF, 16'hBEEF, 1'b0, 3'b001);
    wait_done("eq_casc", 4, 3'b001);
    issue(16'hBEEF, 16'hBEEF, 1'b0, 3'b110);
    wait_done("eq_nonhot", 4, 3'b110);

    // A start raised while busy must be dropped; done still lands 4 cycles after the first start edge.
    issue(16'h00F0, 16'h00F1, 1'b0, 3'b010);
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_ign", 3, 3'b100);
    issue(16'h2000, 16'h1000, 1'b0, 3'b010);
    wait_done("b2b", 1, 3'b001);

    issue(16'h0001, 16'h0002, 1'b0, 3'b010);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_leg", int'({bus.L, bus.E, bus.G}), 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    issue(16'h0003, 16'h0003, 1'b0, 3'b010);
    wait_done("post_rst_eq", 4, 3'b010);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands one DIGIT-bit digit per clock, starting at the most-significant digit and stopping at the first differing digit. It keeps the cascade-input convention of the combinational digit comparators (l/e/g in, L/E/G out), so its result can chain with them. It adds a signed mode and a start/busy/done handshake, and sits in datapaths where wide operands make a single-cycle compare chain too slow.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of DIGIT, ≥ DIGIT.
- DIGIT, 4: bits compared per cycle; N = WIDTH/DIGIT digits.
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- sgn  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- l, e, g  input  1 each  cascade inputs (less/equal/greater from lower-order stage); sampled with start.
- busy  output  1  compare in progress.
- done  output  1  one-cycle pulse: L/E/G just updated.
- L, E, G  output  1 each  result (A<B, A==B, A>B); registered, held until the next completion.

## Operation
- States: IDLE, COMPARE. Digit index idx, $clog2(N) bits (min 1).
- IDLE:
  - start=1 at a clock edge latches a, b, sgn, l, e, g.
  - Sets idx=N-1, busy=1 and moves to COMPARE.
- COMPARE, each edge, digit idx of latched A vs B:
  - When sgn=1 and idx=N-1, invert the MSB of both digits before an unsigned compare.
  - Digit A>B: L/E/G = 0/0/1.
  - Digit A<B: L/E/G = 1/0/0.
  - Either case: done=1, busy=0, go IDLE.
  - Digits equal and idx=0: L/E/G = latched l/e/g, passed through unmodified even if not one-hot; done=1, busy=0, go IDLE.
  - Digits equal and idx>0: idx decrements, stay in COMPARE.
- start while busy=1 is ignored, with no queuing. Inputs a/b/sgn/l/e/g may change freely while busy; only the latched copies are used.
- start in the cycle done=1 is accepted (busy is already 0), so back-to-back operations are allowed.
- Reset, including mid-operation: state IDLE, busy=0, done=0, L=0, E=0, G=0, idx=0, latched operands cleared. The in-flight compare is lost and produces no done.

## Timing
- Start accepted at edge t0. The deciding digit is evaluated at edge tk, where k = number of digits examined, 1 ≤ k ≤ N.
- done=1 and new L/E/G are visible in the cycle after edge tk, i.e. k cycles after the start edge:
  - Minimum latency 1 cycle (MSB digits differ).
  - Maximum latency N cycles (all upper digits equal).
- busy is high from the cycle after t0 through the cycle before done, so it is low during the done cycle.
- done is high for exactly one cycle per accepted start.
- L/E/G change only at a completion edge or on reset.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=16, DIGIT=4, with cascade inputs l/e/g = 0/1/0 unless stated.
- Unsigned, differs in LSB digit: a=0x1234, b=0x1235, sgn=0, start 1 cycle -> busy 4 cycles before done; done with L/E/G=1/0/0, 4 cycles after start edge.
- MSB early exit, both modes:
  - a=0x9000, b=0x1000, sgn=0 -> done after 1 cycle, G=1.
  - Same operands with sgn=1 -> done after 1 cycle, L=1.
- Equality with cascade pass-through: a=b=0xBEEF, l/e/g=0/0/1 -> done after 4 cycles, L/E/G=0/0/1.
- Equality with non-one-hot cascade: a=b=0xBEEF, l/e/g=1/1/0 -> done after 4 cycles, L/E/G=1/1/0.
- Busy and back-to-back handling:
  - While busy on a=0x00F0 vs b=0x00F1, assert start with a=0xFFFF, b=0x0000 -> ignored; single done after 4 cycles, L=1.
  - Then start in the done cycle with a=0x2000, b=0x1000 -> accepted; done 1 cycle later, G=1.
- Reset mid-operation: start a=0x0001, b=0x0002, assert rst after 2 cycles -> busy, done, L, E, G all 0 immediately and asynchronously; no done afterwards. Next start (a=0x0003, b=0x0003) completes normally with E=1 after 4 cycles.
